vec_dmem_ctrl: RTL and testbench

VEC_DMEM_CTRL -- requirements
Module: vec_dmem_ctrl

---
 rtl/vec_dmem_ctrl_pkg.sv | 25 ++
 rtl/vec_dmem_ctrl_if.sv | 40 ++++
 rtl/vec_dmem_ctrl_sp_ram.sv | 27 ++
 rtl/vec_dmem_ctrl.sv | 153 +++++++++++++++
 tb/tb_vec_dmem_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_dmem_ctrl_pkg.sv
// Shared types and constants for the vector data-memory controller.
//   state_e    : controller states (IDLE, SCALAR, VEC, RESP)
//   LANES      : number of vector lanes (4)
//   WORD_W     : data/address word width (32)
//   lane_vec_t : packed 4 x 32 lane array, lane 0 in the low word
//   word_oor   : 1 when a word index lies beyond the memory depth
package vdmem_pkg;

  localparam int LANES  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALAR = 2'd1,
    VEC    = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef logic [LANES-1:0][WORD_W-1:0] lane_vec_t;

  function automatic logic word_oor(input logic [29:0] word_idx, input int unsigned depth);
    return {2'b00, word_idx} >= depth;
  endfunction

endpackage

// File: rtl/vec_dmem_ctrl_if.sv
// Processor-side request/response bundle for vec_dmem_ctrl.
//   master : processor (drives req_*, DataAdr*, WriteData*)
//   slave  : controller (drives req_ready, resp_valid, ReadData*)
// With VDMEM_RANGE_CHECK_EN defined the bundle carries err, driven by the
// controller and meaningful only while resp_valid is high.
interface vec_dmem_ctrl_if;
  import vdmem_pkg::*;

  logic              req_valid;
  logic              req_vec;
  logic              req_we;
  logic [WORD_W-1:0] DataAdrM;
  logic [WORD_W-1:0] WriteDataM;
  lane_vec_t         DataAdrVecM;
  lane_vec_t         WriteDataMVec;
  logic              req_ready;
  logic              resp_valid;
  logic [WORD_W-1:0] ReadDataM;
  lane_vec_t         ReadDataVecM;
`ifdef VDMEM_RANGE_CHECK_EN
  logic              err;
`endif

  modport master (
    output req_valid, req_vec, req_we, DataAdrM, WriteDataM, DataAdrVecM, WriteDataMVec,
    input  req_ready, resp_valid, ReadDataM, ReadDataVecM
`ifdef VDMEM_RANGE_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  req_valid, req_vec, req_we, DataAdrM, WriteDataM, DataAdrVecM, WriteDataMVec,
    output req_ready, resp_valid, ReadDataM, ReadDataVecM
`ifdef VDMEM_RANGE_CHECK_EN
    , output err
`endif
  );

endinterface

// File: rtl/vec_dmem_ctrl_sp_ram.sv
// sp_ram: single-port DEPTH x WIDTH RAM, synchronous write, registered read
// (1-cycle latency). No reset: contents survive a controller reset.
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after addr is presented
module sp_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vec_dmem_ctrl.sv
// vec_dmem_ctrl: scalar / 4-lane vector data-memory controller on a single-
// port RAM. One request at a time; vector lanes are serviced 0..3, one per
// cycle, so duplicate write addresses leave the highest lane's data.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : vec_dmem_ctrl_if.slave request/response bundle
// Optional feature macro VDMEM_RANGE_CHECK_EN: adds bus.err, suppresses
// out-of-range writes and returns 0 for out-of-range reads. Without it,
// addresses wrap modulo DEPTH.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SCALAR | single RAM access for a scalar request
// VEC    | one RAM access per lane, lane_cnt 0..3
// RESP   | resp_valid pulse, read results presented
module vec_dmem_ctrl #(
  parameter int DEPTH = 64,
  parameter int LANES = 4
) (
  input  logic           clk,
  input  logic           reset,
  vec_dmem_ctrl_if.slave bus
);
  import vdmem_pkg::*;

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_SCALAR  = SCALAR;
  localparam logic [1:0] S_VEC     = VEC;
  localparam logic [1:0] S_RESP    = RESP;
  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  logic [1:0]              state;
  logic [1:0]              lane_cnt;
  logic                    cap_vec;
  logic                    cap_we;
  lane_vec_t               cap_adr;
  lane_vec_t               cap_wd;
  logic [2:0][WORD_W-1:0]  stage;
  logic [WORD_W-1:0]       rd_q;
  lane_vec_t               rdv_q;

  logic                    access;
  logic                    accept;
  logic [WORD_W-1:0]       cur_adr;
  logic                    ram_we;
  logic [AW-1:0]           ram_addr;
  logic [WORD_W-1:0]       ram_rdata;
  logic [WORD_W-1:0]       rd_word;
  logic                    rd_scalar;
  logic                    rd_vector;
  logic                    unused_adr;

  assign access   = (state == S_SCALAR) || (state == S_VEC);
  assign accept   = bus.req_valid && bus.req_ready;
  // a scalar request lives in lane 0 of the capture arrays, and lane_cnt is 0 in SCALAR
  assign cur_adr  = cap_adr[lane_cnt];
  assign ram_addr = cur_adr[AW+1:2];
  assign unused_adr = ^cap_adr;

`ifdef VDMEM_RANGE_CHECK_EN
  logic [LANES-1:0] lane_oor;
  logic [1:0]       rd_lane;

  always_comb begin
    lane_oor = '0;
    for (int l = 0; l < LANES; l++) lane_oor[l] = word_oor(cap_adr[l][31:2], 32'(DEPTH));
  end

  // RAM data seen this cycle belongs to the lane issued last cycle
  assign rd_lane = (state == S_RESP) ? (cap_vec ? LAST_LANE : 2'd0) : (lane_cnt - 2'd1);
  // reset gates the write so an aborted vector leaves later lanes untouched
  assign ram_we  = reset && access && cap_we && !lane_oor[lane_cnt];
  assign rd_word = lane_oor[rd_lane] ? '0 : ram_rdata;
  assign bus.err = reset && (state == S_RESP) && (cap_vec ? (|lane_oor) : lane_oor[0]);
`else
  assign ram_we  = reset && access && cap_we;
  assign rd_word = ram_rdata;
`endif

  sp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cap_wd[lane_cnt]),
    .rdata (ram_rdata)
  );

  assign bus.req_ready  = reset && (state == S_IDLE);
  assign bus.resp_valid = reset && (state == S_RESP);

  // The last RAM word only arrives in RESP, so results are forwarded
  // combinationally in that cycle and held in rd_q/rdv_q afterwards.
  assign rd_scalar = (state == S_RESP) && !cap_vec && !cap_we;
  assign rd_vector = (state == S_RESP) &&  cap_vec && !cap_we;

  assign bus.ReadDataM    = rd_scalar ? rd_word : rd_q;
  assign bus.ReadDataVecM = rd_vector ? lane_vec_t'({rd_word, stage}) : rdv_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      lane_cnt <= '0;
      rd_q     <= '0;
      rdv_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= bus.req_vec ? S_VEC : S_SCALAR;
            lane_cnt <= '0;
          end
        end
        S_SCALAR: state <= S_RESP;
        S_VEC: begin
          if (lane_cnt == LAST_LANE) begin
            state    <= S_RESP;
            lane_cnt <= '0;
          end else begin
            lane_cnt <= lane_cnt + 2'd1;
          end
        end
        S_RESP: begin
          if (rd_scalar) rd_q  <= rd_word;
          if (rd_vector) rdv_q <= lane_vec_t'({rd_word, stage});
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && accept) begin
      cap_vec <= bus.req_vec;
      cap_we  <= bus.req_we;
      if (bus.req_vec) begin
        cap_adr <= bus.DataAdrVecM;
        cap_wd  <= bus.WriteDataMVec;
      end else begin
        cap_adr <= {bus.DataAdrVecM[3:1], bus.DataAdrM};
        cap_wd  <= {bus.WriteDataMVec[3:1], bus.WriteDataM};
      end
    end
    if (state == S_VEC && !cap_we && lane_cnt != 2'd0) stage[lane_cnt - 2'd1] <= rd_word;
  end

endmodule

// File: tb/tb_vec_dmem_ctrl.sv
module tb_vec_dmem_ctrl;
  import vdmem_pkg::*;

  localparam int DEPTH = 64;

  logic clk;
  logic reset;
  vec_dmem_ctrl_if bus ();

  vec_dmem_ctrl #(.DEPTH(DEPTH), .LANES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] exp_rd;
  lane_vec_t   exp_rdv;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_oor(input logic [31:0] a);
`ifdef VDMEM_RANGE_CHECK_EN
    return (a >> 2) >= DEPTH;
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return (32'($urandom_range(0, DEPTH-1)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic run_txn(input bit vec, input bit we, input logic [31:0] adr, input logic [31:0] wd,
                         input lane_vec_t adrv, input lane_vec_t wdv, input string tag);
    int nl;
    int lat;
    int wc;
    logic [31:0] a;
`ifdef VDMEM_RANGE_CHECK_EN
    bit e_err;
    e_err = 1'b0;
`endif
    nl = vec ? 4 : 1;
    for (int l = 0; l < nl; l++) begin
      a = vec ? adrv[l] : adr;
      if (m_oor(a)) begin
`ifdef VDMEM_RANGE_CHECK_EN
        e_err = 1'b1;
`endif
        if (!we) begin
          if (vec) exp_rdv[l] = '0; else exp_rd = '0;
        end
      end else if (we) begin
        mdl[m_idx(a)] = vec ? wdv[l] : wd;
      end else if (vec) begin
        exp_rdv[l] = mdl[m_idx(a)];
      end else begin
        exp_rd = mdl[m_idx(a)];
      end
    end

    bus.req_vec       = vec;
    bus.req_we        = we;
    bus.DataAdrM      = adr;
    bus.WriteDataM    = wd;
    bus.DataAdrVecM   = adrv;
    bus.WriteDataMVec = wdv;
    bus.req_valid     = 1'b1;
    wc = 0;
    while (!bus.req_ready && wc < 20) begin
      @(posedge clk); #1;
      wc++;
    end
    chk({tag, "_ready"}, bus.req_ready, 1'b1);
    @(posedge clk); #1;
    // scramble inputs after acceptance: the controller must use its captured copy
    bus.req_valid     = 1'b0;
    bus.req_we        = ~we;
    bus.DataAdrM      = $urandom;
    bus.WriteDataM    = $urandom;
    bus.DataAdrVecM   = {$urandom, $urandom, $urandom, $urandom};
    bus.WriteDataMVec = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, vec ? 5 : 2);
    chk({tag, "_rd"}, bus.ReadDataM, exp_rd);
    chk({tag, "_rdv"}, bus.ReadDataVecM, exp_rdv);
`ifdef VDMEM_RANGE_CHECK_EN
    chk({tag, "_err"}, bus.err, e_err);
`endif
    @(posedge clk); #1;
    chk({tag, "_pulse"}, bus.resp_valid, 1'b0);
    chk({tag, "_hold"}, {bus.ReadDataVecM, bus.ReadDataM}, {exp_rdv, exp_rd});
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    lane_vec_t av;
    lane_vec_t dv;
    logic [31:0] a0;
    int n_acc;
    int n_resp;
    int run;
    int maxrun;

    reset             = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_vec       = 1'b0;
    bus.req_we        = 1'b0;
    bus.DataAdrM      = '0;
    bus.WriteDataM    = '0;
    bus.DataAdrVecM   = '0;
    bus.WriteDataMVec = '0;
    exp_rd            = '0;
    exp_rdv           = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.req_ready, 1'b0);
    chk("rst_resp", bus.resp_valid, 1'b0);
    chk("rst_rd", bus.ReadDataM, 32'h0);
    chk("rst_rdv", bus.ReadDataVecM, 128'h0);
    reset = 1'b1;
    #1;
    chk("rel_ready", bus.req_ready, 1'b1);

    // fill memory with known contents
    for (int w = 0; w < DEPTH; w += 4) begin
      for (int l = 0; l < 4; l++) begin
        av[l] = 32'((w + l) * 4);
        dv[l] = $urandom;
      end
      run_txn(1'b1, 1'b1, '0, '0, av, dv, "init");
    end

    run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, '0, '0, "sw");
    run_txn(1'b0, 1'b0, 32'h10, 32'h0, '0, '0, "sr");
    chk("sr_val", bus.ReadDataM, 32'hDEADBEEF);

    av = {32'hC, 32'h8, 32'h4, 32'h0};
    dv = {32'd4, 32'd3, 32'd2, 32'd1};
    run_txn(1'b1, 1'b1, '0, '0, av, dv, "vw");
    run_txn(1'b1, 1'b0, '0, '0, av, '0, "vr");
    chk("vr_val", bus.ReadDataVecM, {32'd4, 32'd3, 32'd2, 32'd1});

    av = {4{32'h20}};
    dv = {32'hD, 32'hC, 32'hB, 32'hA};
    run_txn(1'b1, 1'b1, '0, '0, av, dv, "dup_w");
    run_txn(1'b0, 1'b0, 32'h20, '0, '0, '0, "dup_r");
    chk("dup_val", bus.ReadDataM, 32'hD);

    // back-pressure: hold a vector read request for three full transactions
    av = {32'h2C, 32'h28, 32'h24, 32'h20};
    for (int l = 0; l < 4; l++) exp_rdv[l] = mdl[m_idx(av[l])];
    bus.req_vec     = 1'b1;
    bus.req_we      = 1'b0;
    bus.DataAdrVecM = av;
    bus.req_valid   = 1'b1;
    n_acc = 0; n_resp = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 18; c++) begin
      if (bus.req_ready) begin
        n_acc++;
        run = 0;
      end else begin
        run++;
        if (run > maxrun) maxrun = run;
      end
      if (bus.resp_valid) n_resp++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    chk("bp_acc", n_acc, 3);
    chk("bp_resp", n_resp, 3);
    chk("bp_busy", maxrun, 5);
    chk("bp_rdv", bus.ReadDataVecM, exp_rdv);

    // reset while lane 2 of a vector write is in progress
    av = {32'h4C, 32'h48, 32'h44, 32'h40};
    dv = {$urandom, $urandom, $urandom, $urandom};
    bus.req_vec       = 1'b1;
    bus.req_we        = 1'b1;
    bus.DataAdrVecM   = av;
    bus.WriteDataMVec = dv;
    bus.req_valid     = 1'b1;
    chk("abrt_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abrt_resp_lo", bus.resp_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abrt_idle", bus.req_ready, 1'b1);
    chk("abrt_rd0", {bus.ReadDataVecM, bus.ReadDataM}, 160'h0);
    mdl[m_idx(av[0])] = dv[0];
    mdl[m_idx(av[1])] = dv[1];
    exp_rd  = '0;
    exp_rdv = '0;
    n_resp = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.resp_valid) n_resp++;
      @(posedge clk); #1;
    end
    chk("abrt_noresp", n_resp, 0);
    run_txn(1'b1, 1'b0, '0, '0, av, '0, "abrt_rb");

    // out-of-range scalar write aliasing word 1
    run_txn(1'b0, 1'b1, 32'h104, 32'h55, '0, '0, "oor_w");
    run_txn(1'b0, 1'b0, 32'h4, '0, '0, '0, "oor_r");

    for (int t = 0; t < 150; t++) begin
      bit v;
      bit w;
      v  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a0 = rand_addr();
      for (int l = 0; l < 4; l++) begin
        av[l] = rand_addr();
        dv[l] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) av = {av[0], av[0], av[1], av[0]};
      run_txn(v, w, a0, $urandom, av, dv, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
